// File: rtl/demux4_stream_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 stream demultiplexer.
package demux4_stream_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a channel select, used to steer the load strobes.
  function automatic logic [NCH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NCH-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux4_stream_slot.sv
// One output channel of the demux: a one-entry buffer with a two-state
// EMPTY/FULL controller and a wrapping count of words loaded into it.
module demux4_stream_slot
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,       // only asserted while can_load is high
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  // A full slot can take a new word in the same cycle its consumer drains it.
  assign can_load  = (state_q == SLOT_EMPTY) || out_ready;
  assign out_valid = (state_q == SLOT_FULL);
  assign q         = data_q;
  assign count     = count_q;

  // Next-state, data-hold and counter update for this slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (load)           state_d = SLOT_FULL;
        else if (out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (load) begin
      data_d  = d;
      count_d = count_q + CNT_W'(1);
    end
  end

  // Slot registers; reset discards any buffered word and clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer. Each accepted input word is routed to the
// channel named by s_sel and held in that channel's one-entry buffer.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. Valid never waits on ready; the producer holds
// its word (and s_sel) stable while valid is high and ready is low. Here
// s_ready depends only on the selected slot, so a stalled channel blocks
// only traffic addressed to it while all other channels drain freely.
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SEL_W-1:0]   s_sel,
  input  logic [WIDTH-1:0]   s_data,
  output logic [NCH-1:0]     m_valid,
  input  logic [NCH-1:0]     m_ready,
  output logic [NCH*WIDTH-1:0] m_data,
  output logic [NCH*CNT_W-1:0] m_count
);

  logic [NCH-1:0] can_load;
  logic [NCH-1:0] load;
  logic           accept;

  // Input acceptance and one-hot steering of the load strobe.
  always_comb begin
    s_ready = rst_n && can_load[s_sel];
    accept  = s_valid && s_ready;
    load    = accept ? sel_decode(s_sel) : '0;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux4_stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .d         (s_data),
      .out_ready (m_ready[i]),
      .out_valid (m_valid[i]),
      .q         (m_data[i*WIDTH +: WIDTH]),
      .count     (m_count[i*CNT_W +: CNT_W]),
      .can_load  (can_load[i])
    );
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream: reset, routing, backpressure,
// drain-and-load in one cycle, counter wrap with isolation, mid-op reset.
module tb_demux4_stream;

  localparam int WIDTH = 8;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_sel;
  logic [7:0]  s_data;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [31:0] m_count;

  int checks;
  int errors;
  int blocked;

  demux4_stream #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] data);
    s_valid = v;
    s_sel   = sel;
    s_data  = data;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    blocked = 0;
    rst_n   = 1'b0;
    m_ready = 4'hF;
    drive(1'b1, 2'd0, 8'h00);

    // 1 Reset held with s_valid high.
    step();
    step();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {28'd0, m_valid}, 32'd0);
    check("rst_m_count", m_count, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    drive(1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;

    // 2 Routing to each channel with all consumers ready.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'(8'hA0 + i));
      #1;
      check("route_s_ready", {31'd0, s_ready}, 32'd1);
      step();
      check("route_m_valid", {28'd0, m_valid}, 32'(1 << i));
      check("route_m_data", {24'd0, m_data[i*8 +: 8]}, 32'(8'hA0 + i));
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    check("route_drained", {28'd0, m_valid}, 32'd0);
    check("route_counts", m_count, 32'h01010101);
    check("route_data_hold", m_data, 32'hA3A2A1A0);

    // 3 Backpressure on channel 2.
    m_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'h55);
    step();
    check("bp_first_valid", {28'd0, m_valid}, 32'h4);
    check("bp_first_data", {24'd0, m_data[23:16]}, 32'h55);
    drive(1'b1, 2'd2, 8'h66);
    #1;
    check("bp_blocked", {31'd0, s_ready}, 32'd0);
    step();
    check("bp_held_data", {24'd0, m_data[23:16]}, 32'h55);
    check("bp_held_count", {24'd0, m_count[23:16]}, 32'd2);
    m_ready = 4'hF;
    #1;
    check("bp_unblocked", {31'd0, s_ready}, 32'd1);
    step();
    check("bp_second_valid", {28'd0, m_valid}, 32'h4);
    check("bp_second_data", {24'd0, m_data[23:16]}, 32'h66);
    check("bp_second_count", {24'd0, m_count[23:16]}, 32'd3);
    drive(1'b0, 2'd0, 8'h00);
    step();
    check("bp_drained", {28'd0, m_valid}, 32'd0);

    // 4 Drain and load channel 1 in the same cycle.
    m_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h11);
    step();
    check("dl_first_data", {24'd0, m_data[15:8]}, 32'h11);
    m_ready = 4'hF;
    drive(1'b1, 2'd1, 8'h22);
    #1;
    check("dl_s_ready", {31'd0, s_ready}, 32'd1);
    step();
    check("dl_no_bubble", {28'd0, m_valid}, 32'h2);
    check("dl_new_data", {24'd0, m_data[15:8]}, 32'h22);
    check("dl_count", {24'd0, m_count[15:8]}, 32'd3);
    drive(1'b0, 2'd0, 8'h00);
    step();
    check("dl_drained", {28'd0, m_valid}, 32'd0);

    // 5 Counter wrap on channel 3 while channel 0 is stalled full.
    m_ready = 4'b1110;
    drive(1'b1, 2'd0, 8'h77);
    step();
    check("wrap_ch0_load", {24'd0, m_data[7:0]}, 32'h77);
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'd3, 8'(k));
      #1;
      if (!s_ready) blocked++;
      step();
      if (k == 254) check("wrap_count_zero", {24'd0, m_count[31:24]}, 32'd0);
    end
    check("wrap_never_blocked", 32'(blocked), 32'd0);
    check("wrap_ch3_count", {24'd0, m_count[31:24]}, 32'd1);
    check("wrap_ch3_data", {24'd0, m_data[31:24]}, 32'hFF);
    check("wrap_ch0_data", {24'd0, m_data[7:0]}, 32'h77);
    check("wrap_ch0_count", {24'd0, m_count[7:0]}, 32'd2);
    drive(1'b0, 2'd0, 8'h00);
    step();
    check("wrap_ch0_still_full", {28'd0, m_valid}, 32'h1);

    // 6 Asynchronous reset between edges with slots 0 and 2 full.
    m_ready = 4'b1010;
    drive(1'b1, 2'd2, 8'h99);
    step();
    check("mr_pre_valid", {28'd0, m_valid}, 32'h5);
    drive(1'b0, 2'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_m_valid", {28'd0, m_valid}, 32'd0);
    check("mr_m_count", m_count, 32'd0);
    check("mr_m_data", m_data, 32'd0);
    check("mr_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 4'hF;
    drive(1'b1, 2'd1, 8'h5A);
    step();
    check("mr_after_valid", {28'd0, m_valid}, 32'h2);
    check("mr_after_data", m_data, 32'h00005A00);
    check("mr_after_count", m_count, 32'h00000100);
    drive(1'b0, 2'd0, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
